prog_loader: RTL

Boot-time program loader that writes 19-bit instructions into the processor's instruction memory. It takes the program as a byte stream with a valid/ready handshake, assembles each 3-byte word, and drives the instruction-memory write port. It holds the processor core in reset until a complete, checksum-verified image is stored. It sits between the host byte link and the instruction memory, which is the memory the core's fetch stage reads from.

---
 rtl/prog_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream -> 19-bit instruction-memory writes, holds the core in reset until the image verifies.
// Latency: one WRITE cycle after the third byte of each word; done/error visible the cycle after the deciding byte.
// Backpressure: byte_ready drops during WRITE, DONE and ERR and while reset is high; bytes offered then are not consumed.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   byte_in, byte_valid, byte_ready input byte stream, valid/ready handshake
//   imem_we, imem_addr, imem_wdata  instruction-memory write port
//   cpu_reset, done, error          core reset and load status
module prog_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [18:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [3:0] {
    ST_CNT_HI,
    ST_CNT_LO,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  // Largest legal word count: the full memory capacity.
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;       // N-1, address of the final word
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            cnt_hi_q, cnt_hi_d;
  logic [2:0]            b0_q, b0_d;
  logic [7:0]            b1_q, b1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [18:0]           wdata_q, wdata_d;

  logic                  accept;
  logic [15:0]           n_word;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    sum_d    = sum_q;
    cnt_hi_d = cnt_hi_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    byte_ready = ~reset && (state_q inside {ST_CNT_HI, ST_CNT_LO, ST_B0, ST_B1, ST_B2, ST_CSUM});
    accept     = byte_valid && byte_ready;
    n_word     = {cnt_hi_q, byte_in};

    case (state_q)
      ST_CNT_HI: begin
        if (accept) begin
          cnt_hi_d = byte_in;
          state_d  = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          if (n_word == 16'd0 || {1'b0, n_word} > CAP) begin
            state_d = ST_ERR;
          end else begin
            // N <= 2^ADDR_WIDTH, so N-1 always fits in the address width.
            last_d  = ADDR_WIDTH'(n_word - 16'd1);
            state_d = ST_B0;
          end
        end
      end
      ST_B0: begin
        if (accept) begin
          sum_d = sum_q + byte_in;
          if (byte_in[7:3] != 5'd0) begin
            state_d = ST_ERR;
          end else begin
            b0_d    = byte_in[2:0];
            state_d = ST_B1;
          end
        end
      end
      ST_B1: begin
        if (accept) begin
          sum_d   = sum_q + byte_in;
          b1_d    = byte_in;
          state_d = ST_B2;
        end
      end
      ST_B2: begin
        if (accept) begin
          sum_d   = sum_q + byte_in;
          // Address and data are registered here so they are stable for the whole WRITE cycle
          // and hold afterwards.
          addr_d  = idx_q;
          wdata_d = {b0_q, b1_q, byte_in};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (idx_q == last_q) begin
          state_d = ST_CSUM;
        end else begin
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = ST_B0;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_d = (byte_in == sum_q) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_CNT_HI;
      idx_q    <= '0;
      last_q   <= '0;
      sum_q    <= '0;
      cnt_hi_q <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      sum_q    <= sum_d;
      cnt_hi_q <= cnt_hi_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);
  assign cpu_reset  = (state_q != ST_DONE);

endmodule
